alu32: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 47 ++++
 rtl/alu32.sv | 82 ++++++++
 tb/tb_alu32.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the core decoder and by alu32,
// plus the shift-mode select for the optional barrel shifter.
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 32;
  localparam int unsigned ALU_SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_OP_ZERO  = 4'd0,
    ALU_OP_ADD   = 4'd1,
    ALU_OP_SUB   = 4'd2,
    ALU_OP_LT    = 4'd3,
    ALU_OP_LTU   = 4'd4,
    ALU_OP_AND   = 4'd5,
    ALU_OP_OR    = 4'd6,
    ALU_OP_XOR   = 4'd7,
    ALU_OP_SLL   = 4'd8,
    ALU_OP_SRL   = 4'd9,
    ALU_OP_SRA   = 4'd10,
    ALU_OP_PASSB = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter. Left shifts reuse the right-shift network by
// bit-reversing the operand before and the result after.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  input  shift_mode_t        mode,
  output logic [WIDTH-1:0]   result
);

  logic             left;
  logic             fill;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] fill_mask;

  // Reverse for left shifts, run the right-shift stages, reverse back.
  always_comb begin
    left      = (mode == SHIFT_SLL);
    fill      = (mode == SHIFT_SRA) & data[WIDTH-1];
    operand   = '0;
    fill_mask = '0;
    result    = '0;

    for (int i = 0; i < int'(WIDTH); i++) begin
      operand[i] = left ? data[WIDTH-1-i] : data[i];
    end

    stage = operand;
    for (int s = 0; s < int'(SHAMT_W); s++) begin
      if (amount[s]) begin
        // Bits vacated at the top of this stage take the fill value.
        fill_mask = ~({WIDTH{1'b1}} >> (1 << s));
        stage     = (stage >> (1 << s)) | (fill_mask & {WIDTH{fill}});
      end
    end

    for (int i = 0; i < int'(WIDTH); i++) begin
      result[i] = left ? stage[WIDTH-1-i] : stage[i];
    end
  end

endmodule

// File: rtl/alu32.sv
// 32-bit RV32I ALU: combinational result/zero plus a registered copy.
// Optional feature: define ALU_SHIFT_EN to build the barrel shifter for
// SLL/SRL/SRA; otherwise those opcodes return 0 like the reserved codes.
module alu32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q
);

  alu_op_t op;
  assign op = alu_op_t'(alu_op);

`ifdef ALU_SHIFT_EN
  shift_mode_t      shift_mode;
  logic [WIDTH-1:0] shift_result;

  // Map the opcode onto the shifter mode; only consumed for ops 8-10.
  always_comb begin
    shift_mode = SHIFT_SRA;
    if (op == ALU_OP_SLL) begin
      shift_mode = SHIFT_SLL;
    end else if (op == ALU_OP_SRL) begin
      shift_mode = SHIFT_SRL;
    end
  end

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (ALU_SHAMT_W)
  ) u_shifter (
    .data   (alu_a),
    .amount (alu_b[ALU_SHAMT_W-1:0]),
    .mode   (shift_mode),
    .result (shift_result)
  );
`endif

  // Result mux; reserved opcodes (and shifts when not built) give 0.
  always_comb begin
    alu_out = '0;
    case (op)
      ALU_OP_ADD:   alu_out = alu_a + alu_b;
      ALU_OP_SUB:   alu_out = alu_a - alu_b;
      ALU_OP_LT:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_OP_LTU:   alu_out = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      ALU_OP_AND:   alu_out = alu_a & alu_b;
      ALU_OP_OR:    alu_out = alu_a | alu_b;
      ALU_OP_XOR:   alu_out = alu_a ^ alu_b;
`ifdef ALU_SHIFT_EN
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_SRA:   alu_out = shift_result;
`endif
      ALU_OP_PASSB: alu_out = alu_b;
      default:      alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  // Registered copy for pipelined consumers; reset value matches a zero result.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_out_q <= alu_out;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Directed self-checking bench for alu32. Shift expectations follow ALU_SHIFT_EN.
module tb_alu32;

  logic        clock;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] alu_out_q;
  logic        zero_q;

  int unsigned n_checks;
  int unsigned n_pass;

  alu32 #(
    .WIDTH (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .zero      (zero),
    .alu_out_q (alu_out_q),
    .zero_q    (zero_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a vector away from the edge and check the combinational outputs.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clock);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    #1;
    check(tag, alu_out, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
  endtask

  task automatic check_reg(input string tag, input logic [31:0] exp);
    @(posedge clock);
    #1;
    check({tag, "_q"}, alu_out_q, exp);
    check({tag, "_zq"}, {31'b0, zero_q}, {31'b0, (exp == 32'h0)});
  endtask

  logic [31:0] sll_exp, srl_exp, sra_exp, sh0_exp, sll31_exp, sra31_exp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef ALU_SHIFT_EN
    sll_exp   = 32'h0000_0002;
    srl_exp   = 32'h4000_0000;
    sra_exp   = 32'hC000_0000;
    sh0_exp   = 32'h8000_0001;
    sll31_exp = 32'h8000_0000;
    sra31_exp = 32'hFFFF_FFFF;
`else
    sll_exp   = 32'h0;
    srl_exp   = 32'h0;
    sra_exp   = 32'h0;
    sh0_exp   = 32'h0;
    sll31_exp = 32'h0;
    sra31_exp = 32'h0;
`endif

    // Reset held for two edges: registers at reset values, comb path live.
    reset  = 1'b1;
    alu_op = 4'd1;
    alu_a  = 32'd2;
    alu_b  = 32'd3;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_q", alu_out_q, 32'h0);
    check("rst_zq", {31'b0, zero_q}, 32'h1);
    check("rst_comb", alu_out, 32'd5);
    check("rst_comb_zero", {31'b0, zero}, 32'h0);

    @(negedge clock);
    reset = 1'b0;
    check_reg("rel", 32'd5);

    // Arithmetic wrap.
    run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0);
    check_reg("add_wrap", 32'h0);
    run_op("sub_wrap", 4'd2, 32'h0, 32'h1, 32'hFFFF_FFFF);
    check_reg("sub_wrap", 32'hFFFF_FFFF);
    run_op("zero_op", 4'd0, 32'h1234_5678, 32'h1, 32'h0);

    // Signed vs unsigned compare.
    run_op("lt_neg", 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1);
    run_op("ltu_neg", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
    run_op("lt_eq", 4'd3, 32'd5, 32'd5, 32'h0);
    run_op("ltu_eq", 4'd4, 32'd5, 32'd5, 32'h0);
    run_op("ltu_small", 4'd4, 32'h1, 32'hFFFF_FFFF, 32'h1);
    run_op("lt_pos", 4'd3, 32'h1, 32'hFFFF_FFFF, 32'h0);

    // Logic and pass.
    run_op("and", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    run_op("or", 4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    run_op("xor", 4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    run_op("passb", 4'd11, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
    run_op("rsvd13", 4'd13, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0);
    run_op("rsvd15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // Shifts: upper bits of b ignored.
    run_op("sll", 4'd8, 32'h8000_0001, 32'h21, sll_exp);
    run_op("srl", 4'd9, 32'h8000_0001, 32'h21, srl_exp);
    run_op("sra", 4'd10, 32'h8000_0001, 32'h21, sra_exp);
    run_op("srl_amt0", 4'd9, 32'h8000_0001, 32'h20, sh0_exp);
    run_op("sll31", 4'd8, 32'h1, 32'h1F, sll31_exp);
    run_op("sra31", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, sra31_exp);

    // Mid-stream reset then release.
    run_op("pre_rst", 4'd1, 32'd2, 32'd3, 32'd5);
    check_reg("pre_rst", 32'd5);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_q", alu_out_q, 32'h0);
    check("mid_rst_zq", {31'b0, zero_q}, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    alu_a = 32'd10;
    check_reg("post_rst", 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
